hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. Owns PC/IF-ID/ID-EX/EX-MEM/MEM-WB write enables and flushes, PC source select, load-use stalls, beq/bne/JAL redirects and data-memory wait states. Decodes the ID opcode itself to know rt usage. Keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register-address width
MAX_WAIT, 15, max consecutive dmem wait cycles before timeout (1..255)
CNT_W, 16, perf counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_op  in  6  opcode of instruction in ID
id_rs  in  REG_W  rs field in ID
id_rt  in  REG_W  rt field in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  load destination in EX
ex_branch  in  1  beq in EX
ex_bne  in  1  bne in EX
ex_zero  in  1  ALU zero flag in EX
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 JAL target
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  IF/ID -> bubble
id_ex_write  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX -> bubble (controls zeroed)
ex_mem_write  out  1  EX/MEM enable
mem_wb_flush  out  1  MEM/WB -> bubble
dmem_timeout  out  1  sticky timeout error
stall_cnt  out  CNT_W  saturating load-use + mem-wait stall count
flush_cnt  out  CNT_W  saturating redirect count

Behaviour:
- Clock/reset fixed: one clock clk; rst_n asynchronous, active-low.
- States: INIT, RUN, MEM_WAIT. rst_n low -> INIT, counters 0, wait_cnt 0, dmem_timeout 0.
- Outputs are combinational from state and inputs; state, wait_cnt and counters are registered.
- INIT (exactly one cycle after reset release): pc_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1, all *_write=0, pc_sel=00 -> RUN.
- RUN default: all *_write=1, all flushes 0, pc_sel=00.
- rt_used = id_op in {000000, 000100, 000101, 101011}. load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (rt_used & ex_rt==id_rt)).
- taken = (ex_branch & ex_zero) | (ex_bne & ~ex_zero). jal = id_op==000011.
- Priority in RUN, highest first:
  1. dmem_req & ~dmem_ready: freeze. pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_flush=1; go to MEM_WAIT, wait_cnt=1.
  2. taken: pc_sel=01, if_id_flush=1, id_ex_flush=1; flush_cnt++. A load_use or jal in the same cycle is discarded.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt++. One bubble per hazard; the next cycle re-evaluates.
  4. jal: pc_sel=10, if_id_flush=1; flush_cnt++.
- MEM_WAIT: freeze outputs as in item 1; stall_cnt++ each cycle. Exits:
  - dmem_ready=1: outputs revert to RUN default that cycle, no branch/hazard action; next state RUN, wait_cnt=0.
  - wait_cnt==MAX_WAIT and ~dmem_ready: set dmem_timeout and force RUN, treated as completed; otherwise wait_cnt++.
- Counters saturate at all-ones and never wrap. dmem_timeout clears only on reset.
- rst_n assertion mid-wait or mid-stall: immediate return to INIT values; no pending redirect is retained.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_JAL 000011, OP_ADDI, OP_ANDI, OP_ORI), PCSEL_* encodings, state enum. The existing control decoder imports the same constants.
- One sub-module, sat_counter (CNT_W, inc), instantiated twice for the perf counters.

Test Plan:
- Reset release -> cycle 1: pc_write=0, if_id_flush=id_ex_flush=mem_wb_flush=1; cycle 2: RUN defaults, all *_write=1.
- lw $8 in EX (ex_mem_read=1, ex_rt=8), id_op=000000, id_rt=8 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1, stall_cnt=1. Repeat with ex_rt=0 -> no stall. Repeat with id_op=001000, id_rt=8 -> no stall.
- ex_bne=1, ex_zero=0, with load_use and jal also true -> pc_sel=01, if_id_flush=id_ex_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- dmem_req=1, dmem_ready low for 3 cycles then high -> 3 freeze cycles (mem_wb_flush=1, ex_mem_write=0), then release; stall_cnt=3; state RUN.
- dmem_ready held low with MAX_WAIT=15 -> 15 freeze cycles, dmem_timeout=1 and sticky; pipeline resumes.
- Preload stall_cnt near all-ones with CNT_W=4 and force 20 stalls -> holds at 15; rst_n pulse low mid-MEM_WAIT -> counters 0 and INIT sequence.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU constants: opcodes, PC-source encodings and the sequencer state type.
// The control decoder imports the same package so opcode values stay in one place.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JAL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    // Instructions whose rt field is a source operand (R-type, branches, store).
    function automatic logic rt_used(input logic [5:0] op);
        logic used;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: used = 1'b1;
            default:                         used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall sequencer.
// slave = the sequencer, master = the datapath side that supplies stage status.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [5:0]       id_op;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             ex_branch;
    logic             ex_bne;
    logic             ex_zero;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_flush;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_op, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch, ex_bne, ex_zero,
               dmem_req, dmem_ready,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, dmem_timeout, stall_cnt, flush_cnt
    );

    modport master (
        output id_op, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch, ex_bne, ex_zero,
               dmem_req, dmem_ready,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, dmem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: enables/flushes per stage, PC source, load-use stalls,
// branch/JAL redirects and data-memory wait handling with a sticky timeout.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_r, state_s;
    logic [7:0] wait_cnt_r, wait_cnt_s;
    logic       timeout_r, timeout_set_s;
    logic       stall_inc_s, flush_inc_s;
    logic       load_use_s, taken_s, jal_s, mem_stall_s;

    logic       pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s;
    logic       id_ex_flush_s, ex_mem_write_s, mem_wb_flush_s;
    logic [1:0] pc_sel_s;
    logic [CNT_W-1:0] stall_cnt_s, flush_cnt_s;

    assign load_use_s  = bus.ex_mem_read && (bus.ex_rt != {REG_W{1'b0}}) &&
                         ((bus.ex_rt == bus.id_rs) ||
                          (rt_used(bus.id_op) && (bus.ex_rt == bus.id_rt)));
    assign taken_s     = (bus.ex_branch && bus.ex_zero) || (bus.ex_bne && !bus.ex_zero);
    assign jal_s       = (bus.id_op == OP_JAL);
    assign mem_stall_s = bus.dmem_req && !bus.dmem_ready;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            wait_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            timeout_r  <= timeout_r | timeout_set_s;
        end
    end

    // Next-state and per-stage control decode in priority order.
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        timeout_set_s  = 1'b0;
        stall_inc_s    = 1'b0;
        flush_inc_s    = 1'b0;
        pc_write_s     = 1'b1;
        pc_sel_s       = PCSEL_PC4;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_write_s  = 1'b1;
        id_ex_flush_s  = 1'b0;
        ex_mem_write_s = 1'b1;
        mem_wb_flush_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_write_s  = 1'b0;
                ex_mem_write_s = 1'b0;
                if_id_flush_s  = 1'b1;
                id_ex_flush_s  = 1'b1;
                mem_wb_flush_s = 1'b1;
                state_s        = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                    stall_inc_s    = 1'b1;
                    state_s        = ST_MEM_WAIT;
                    wait_cnt_s     = 8'd1;
                end else if (taken_s) begin
                    pc_sel_s      = PCSEL_BR;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    flush_inc_s   = 1'b1;
                end else if (load_use_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                    stall_inc_s   = 1'b1;
                end else if (jal_s) begin
                    pc_sel_s      = PCSEL_JAL;
                    if_id_flush_s = 1'b1;
                    flush_inc_s   = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // Completion and timeout both release the pipeline with no redirect.
                if (bus.dmem_ready) begin
                    state_s    = ST_RUN;
                    wait_cnt_s = 8'd0;
                end else if (wait_cnt_r == MAX_WAIT_C) begin
                    timeout_set_s = 1'b1;
                    state_s       = ST_RUN;
                    wait_cnt_s    = 8'd0;
                end else begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                    stall_inc_s    = 1'b1;
                    wait_cnt_s     = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s    = ST_INIT;
                wait_cnt_s = 8'd0;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_cnt_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt_s)
    );

    assign bus.pc_write     = pc_write_s;
    assign bus.pc_sel       = pc_sel_s;
    assign bus.if_id_write  = if_id_write_s;
    assign bus.if_id_flush  = if_id_flush_s;
    assign bus.id_ex_write  = id_ex_write_s;
    assign bus.id_ex_flush  = id_ex_flush_s;
    assign bus.ex_mem_write = ex_mem_write_s;
    assign bus.mem_wb_flush = mem_wb_flush_s;
    assign bus.dmem_timeout = timeout_r;
    assign bus.stall_cnt    = stall_cnt_s;
    assign bus.flush_cnt    = flush_cnt_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam int MAXW    = 15;

    // Control vector: {pc_write, pc_sel[1:0], if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
    localparam logic [8:0] V_INIT   = 9'b0_00_0_1_0_1_0_1;
    localparam logic [8:0] V_RUN    = 9'b1_00_1_0_1_0_1_0;
    localparam logic [8:0] V_LU     = 9'b0_00_0_0_1_1_1_0;
    localparam logic [8:0] V_BR     = 9'b1_01_1_1_1_1_1_0;
    localparam logic [8:0] V_FREEZE = 9'b0_00_0_0_0_0_0_1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.REG_W(5), .MAX_WAIT(MAXW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = after-reset cycle, 1 = running, 2 = waiting on data memory.
    int m_mode, m_wait, m_stall, m_flush;
    logic m_tout;
    int n_mode, n_wait, n_stall, n_flush;
    logic n_tout;
    logic [8:0] exp_v;

    function automatic logic [8:0] ctrl();
        return {bus.pc_write, bus.pc_sel, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_write, bus.id_ex_flush, bus.ex_mem_write, bus.mem_wb_flush};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic bne, input logic z, input logic req, input logic rdy);
        bus.id_op = op; bus.id_rs = rs; bus.id_rt = rt;
        bus.ex_mem_read = mr; bus.ex_rt = ert;
        bus.ex_branch = br; bus.ex_bne = bne; bus.ex_zero = z;
        bus.dmem_req = req; bus.dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tout = 1'b0;
    endtask

    task automatic model_eval();
        logic hz, tk, jl, mw;
        hz = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.ex_rt == bus.id_rs) ||
              ((bus.id_op inside {6'b000000, 6'b000100, 6'b000101, 6'b101011}) &&
               (bus.ex_rt == bus.id_rt)));
        tk = (bus.ex_branch && bus.ex_zero) || (bus.ex_bne && !bus.ex_zero);
        jl = (bus.id_op == 6'b000011);
        mw = bus.dmem_req && !bus.dmem_ready;
        n_mode = m_mode; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush; n_tout = m_tout;
        exp_v = V_RUN;
        if (m_mode == 0) begin
            exp_v = V_INIT; n_mode = 1;
        end else if (m_mode == 1) begin
            if (mw) begin
                exp_v = V_FREEZE; n_mode = 2; n_wait = 1; n_stall = sat_inc(m_stall);
            end else if (tk) begin
                exp_v = V_BR; n_flush = sat_inc(m_flush);
            end else if (hz) begin
                exp_v = V_LU; n_stall = sat_inc(m_stall);
            end else if (jl) begin
                exp_v = 9'b1_10_1_1_1_0_1_0; n_flush = sat_inc(m_flush);
            end
        end else begin
            if (bus.dmem_ready || m_wait == MAXW) begin
                n_mode = 1; n_wait = 0;
                if (!bus.dmem_ready) n_tout = 1'b1;
            end else begin
                exp_v = V_FREEZE; n_wait = m_wait + 1; n_stall = sat_inc(m_stall);
            end
        end
    endtask

    task automatic step_eval();
        @(negedge clk);
        model_eval();
    endtask

    task automatic step_commit();
        @(posedge clk);
        m_mode = n_mode; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush; m_tout = n_tout;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.dmem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: stall=%0d flush=%0d tout=%b, want 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.dmem_timeout);
        end
        step_eval();
        checks++;
        if (ctrl() !== V_INIT) begin
            errors++; $display("FAIL reset_init_cycle: got %b want %b", ctrl(), V_INIT);
        end
        step_commit();
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL reset_run_cycle: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
    endtask

    task automatic test_load_use();
        do_reset(); step_eval(); step_commit();
        drive(6'b000000, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_eval();
        checks++;
        if (ctrl() !== V_LU) begin
            errors++; $display("FAIL load_use_rt: got %b want %b", ctrl(), V_LU);
        end
        step_commit();
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++; $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL load_use_r0: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
        drive(6'b001000, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL load_use_addi: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++; $display("FAIL load_use_cnt_hold: got %0d want 1", bus.stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        do_reset(); step_eval(); step_commit();
        drive(6'b000011, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_eval();
        checks++;
        if (ctrl() !== V_BR) begin
            errors++; $display("FAIL branch_prio: got %b want %b", ctrl(), V_BR);
        end
        step_commit();
        checks++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
            errors++; $display("FAIL branch_cnts: flush=%0d stall=%0d want 1 0",
                               bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset(); step_eval(); step_commit();
        drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_eval();
            checks++;
            if (ctrl() !== V_FREEZE) begin
                errors++; $display("FAIL mem_freeze_%0d: got %b want %b", i, ctrl(), V_FREEZE);
            end
            step_commit();
        end
        bus.dmem_ready = 1'b1;
        bus.ex_branch = 1'b1; bus.ex_zero = 1'b1;
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL mem_release: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
        checks++;
        if (bus.stall_cnt !== 4'd3 || bus.flush_cnt !== 4'd0) begin
            errors++; $display("FAIL mem_cnts: stall=%0d flush=%0d want 3 0",
                               bus.stall_cnt, bus.flush_cnt);
        end
        idle();
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL mem_back_run: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
    endtask

    task automatic test_timeout();
        int nfreeze;
        do_reset(); step_eval(); step_commit();
        drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nfreeze = 0;
        for (int i = 0; i < 16; i++) begin
            step_eval();
            if (ctrl() === V_FREEZE) nfreeze++;
            step_commit();
        end
        checks++;
        if (nfreeze != MAXW) begin
            errors++; $display("FAIL timeout_freezes: got %0d want %0d", nfreeze, MAXW);
        end
        checks++;
        if (bus.dmem_timeout !== 1'b1 || bus.stall_cnt !== 4'd15) begin
            errors++; $display("FAIL timeout_flag: tout=%b stall=%0d want 1 15",
                               bus.dmem_timeout, bus.stall_cnt);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step_eval();
            checks++;
            if (ctrl() !== V_RUN || bus.dmem_timeout !== 1'b1) begin
                errors++; $display("FAIL timeout_sticky_%0d: ctrl=%b tout=%b want %b 1",
                                   i, ctrl(), bus.dmem_timeout, V_RUN);
            end
            step_commit();
        end
    endtask

    task automatic test_saturation();
        do_reset(); step_eval(); step_commit();
        drive(6'b000000, 5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step_eval(); step_commit();
        end
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++; $display("FAIL stall_saturate: got %0d want 15", bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(); step_eval(); step_commit();
        drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step_eval(); step_commit();
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || ctrl() !== V_INIT) begin
            errors++; $display("FAIL mid_wait_reset: stall=%0d flush=%0d ctrl=%b want 0 0 %b",
                               bus.stall_cnt, bus.flush_cnt, ctrl(), V_INIT);
        end
        idle();
        @(posedge clk); #1 rst_n = 1'b1;
        step_eval();
        checks++;
        if (ctrl() !== V_INIT) begin
            errors++; $display("FAIL mid_wait_init: got %b want %b", ctrl(), V_INIT);
        end
        step_commit();
        step_eval();
        checks++;
        if (ctrl() !== V_RUN) begin
            errors++; $display("FAIL mid_wait_run: got %b want %b", ctrl(), V_RUN);
        end
        step_commit();
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000011, 6'b001000};
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 0) do_reset();
            drive(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0));
            step_eval();
            checks++;
            if (ctrl() !== exp_v) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, ctrl(), exp_v);
            end
            checks++;
            if (bus.stall_cnt !== 4'(m_stall) || bus.flush_cnt !== 4'(m_flush)) begin
                errors++; $display("FAIL rand_cnt[%0d]: stall=%0d flush=%0d want %0d %0d",
                                   i, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
            end
            checks++;
            if (bus.dmem_timeout !== m_tout) begin
                errors++; $display("FAIL rand_tout[%0d]: got %b want %b", i, bus.dmem_timeout, m_tout);
            end
            step_commit();
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
